hazard_ctrl: RTL

Pipeline hazard and stall controller for the five-stage RISC-V core. It sits beside the ID/EX stages and produces every hold, bubble and flush signal for the pipeline registers. It covers load-use interlocks, taken-branch flushes and multi-cycle data-memory waits. It also produces the EX-stage operand forwarding selects, a saturating stall-cycle counter and a sticky memory-timeout flag.

---
 rtl/hazard_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, stall, flush and forwarding controller
module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_hold,
  output logic                  if_id_hold,
  output logic                  id_ex_hold,
  output logic                  ex_mem_hold,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  mem_wb_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_count,
  output logic                  mem_timeout
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WMAX  = WW'(MEM_TIMEOUT);
  localparam logic [WW-1:0] WLAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t          state;
  logic [WW-1:0]   wcnt;
  logic            memStall;
  logic            loadUse;
  logic            branch;
  logic            luStall;
  logic            hitTimeout;

  function automatic logic [1:0] fwdSel(input logic [REG_ADDR_W-1:0] rs);
    if (mem_reg_write && mem_rd != '0 && mem_rd == rs)
      return 2'b01;
    else if (wb_reg_write && wb_rd != '0 && wb_rd == rs)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  always_comb begin
    memStall = mem_req & ~mem_ready;
    loadUse  = ex_mem_read & ex_reg_write & (ex_rd != '0) &
               ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    branch   = ex_branch_taken & ~memStall;
    luStall  = loadUse & ~memStall & ~ex_branch_taken;

    // Everything is gated by rst so the pipeline sees no stray holds while reset is asserted.
    pc_hold       = ~rst & (memStall | luStall);
    if_id_hold    = ~rst & (memStall | luStall);
    id_ex_hold    = ~rst & memStall;
    ex_mem_hold   = ~rst & memStall;
    mem_wb_bubble = ~rst & memStall;
    if_id_flush   = ~rst & branch;
    id_ex_bubble  = ~rst & (branch | luStall);
    fwd_a         = rst ? 2'b00 : fwdSel(ex_rs1);
    fwd_b         = rst ? 2'b00 : fwdSel(ex_rs2);

    // The MEM_TIMEOUT-th consecutive stall cycle; with MEM_TIMEOUT==1 that is the entry cycle.
    hitTimeout = memStall & ((state == RUN) ? (MEM_TIMEOUT == 1) : (wcnt == WLAST));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wcnt        <= '0;
      stall_count <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (memStall) begin
            state <= MEM_WAIT;
            wcnt  <= WW'(1);
          end
        end
        MEM_WAIT: begin
          if (memStall) begin
            if (wcnt != WMAX)
              wcnt <= wcnt + WW'(1);
          end else begin
            state <= RUN;
            wcnt  <= '0;
          end
        end
      endcase
      if (hitTimeout)
        mem_timeout <= 1'b1;
      if (pc_hold && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
